// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker
// Post-run register-file checker. After the program finishes it takes over the
// regfile test port and reads registers 0..NUM_REGS-1, one per cycle. Each
// returned value is compared against a preloaded expected-value table, and the
// pass/checked counts plus an overall pass flag are reported in hardware.
// Optional feature: define REGCHK_FAIL_CAPTURE_EN to add first-failure capture
// outputs (fail_seen, fail_reg, fail_actual).
module regfile_scan_checker #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          exp_we,
  input  logic [$clog2(NUM_REGS)-1:0]   exp_addr,
  input  logic [DATA_WIDTH-1:0]         exp_data,
  input  logic                          exp_valid,
  output logic                          test,
  output logic                          ctrl_writeEnable,
  output logic [$clog2(NUM_REGS)-1:0]   ctrl_readRegA,
  input  logic [DATA_WIDTH-1:0]         data_readRegA,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_REGS+1)-1:0] num_checked,
  output logic [$clog2(NUM_REGS+1)-1:0] num_correct,
  output logic                          all_pass
`ifdef REGCHK_FAIL_CAPTURE_EN
  ,
  output logic                          fail_seen,
  output logic [$clog2(NUM_REGS)-1:0]   fail_reg,
  output logic [DATA_WIDTH-1:0]         fail_actual
`endif
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_REGS - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  state_t                state_reg;
  logic [1:0]            drain_cnt_reg;
  logic [DATA_WIDTH-1:0] exp_mem [NUM_REGS];
  logic [NUM_REGS-1:0]   exp_valid_reg;

  logic                  idle_state;
  logic                  scan_start;
  logic                  table_wr;
  logic                  scan_end;
  logic                  tag_valid;
  logic [AW-1:0]         tag_addr;
  logic                  check_en;
  logic                  match;
  logic [CW-1:0]         checked_next;
  logic [CW-1:0]         correct_next;

  // The checker only ever reads the register file.
  assign ctrl_writeEnable = 1'b0;

  // The table is frozen while a scan is in flight.
  assign idle_state = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign scan_start = start && idle_state;
  assign table_wr   = exp_we && idle_state;

  // Expected data storage; contents are meaningless until marked valid, so no reset.
  always_ff @(posedge clock) begin
    if (table_wr) exp_mem[exp_addr] <= exp_data;
  end

  // Per-entry valid bits, cleared by reset so a fresh table checks nothing.
  always_ff @(posedge clock) begin
    if (reset)         exp_valid_reg           <= '0;
    else if (table_wr) exp_valid_reg[exp_addr] <= exp_valid;
  end

  // Tag the returning read data with the address that produced it.
  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign tag_valid = (state_reg == ST_SCAN);
      assign tag_addr  = ctrl_readRegA;
    end else begin : g_pipe_read
      logic [READ_LAT-1:0] pipe_valid_reg;
      logic [AW-1:0]       pipe_addr_reg [READ_LAT];

      // Shift the issued address/valid along so it lines up with the read data.
      always_ff @(posedge clock) begin
        if (reset) pipe_valid_reg[0] <= 1'b0;
        else       pipe_valid_reg[0] <= (state_reg == ST_SCAN);
        pipe_addr_reg[0] <= ctrl_readRegA;
        for (int i = 1; i < READ_LAT; i++) begin
          if (reset) pipe_valid_reg[i] <= 1'b0;
          else       pipe_valid_reg[i] <= pipe_valid_reg[i-1];
          pipe_addr_reg[i] <= pipe_addr_reg[i-1];
        end
      end

      assign tag_valid = pipe_valid_reg[READ_LAT-1];
      assign tag_addr  = pipe_addr_reg[READ_LAT-1];
    end
  endgenerate

  // Compare the returning word and work out the counter values for this edge.
  always_comb begin
    check_en     = tag_valid && exp_valid_reg[tag_addr];
    match        = check_en && (data_readRegA == exp_mem[tag_addr]);
    checked_next = num_checked + CW'(check_en);
    correct_next = num_correct + CW'(match);
    scan_end     = 1'b0;
    if ((state_reg == ST_SCAN) && (ctrl_readRegA == LAST_ADDR) && (READ_LAT == 0))
      scan_end = 1'b1;
    if ((state_reg == ST_DRAIN) && (drain_cnt_reg == DRAIN_LAST))
      scan_end = 1'b1;
  end

  // Scan sequencer: issue addresses, drain the read pipe, then hold the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      test          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      all_pass      <= 1'b0;
      ctrl_readRegA <= '0;
      num_checked   <= '0;
      num_correct   <= '0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg     <= ST_SCAN;
            test          <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            all_pass      <= 1'b0;
            ctrl_readRegA <= '0;
            num_checked   <= '0;
            num_correct   <= '0;
          end
        end
        ST_SCAN: begin
          num_checked <= checked_next;
          num_correct <= correct_next;
          if (ctrl_readRegA == LAST_ADDR) begin
            ctrl_readRegA <= '0;
            drain_cnt_reg <= '0;
            if (READ_LAT > 0) state_reg <= ST_DRAIN;
          end else begin
            ctrl_readRegA <= ctrl_readRegA + AW'(1);
          end
        end
        ST_DRAIN: begin
          num_checked   <= checked_next;
          num_correct   <= correct_next;
          drain_cnt_reg <= drain_cnt_reg + 2'd1;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (scan_end) begin
        state_reg <= ST_DONE;
        test      <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        all_pass  <= (checked_next == correct_next);
      end
    end
  end

`ifdef REGCHK_FAIL_CAPTURE_EN
  // Remember the first mismatching register and what it actually held.
  always_ff @(posedge clock) begin
    if (reset || scan_start) begin
      fail_seen   <= 1'b0;
      fail_reg    <= '0;
      fail_actual <= '0;
    end else if (check_en && !match && !fail_seen) begin
      fail_seen   <= 1'b1;
      fail_reg    <= tag_addr;
      fail_actual <= data_readRegA;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb_regfile_scan_checker
// Drives two checkers side by side: one against a combinational register file
// model (READ_LAT=0) and one against a two-stage registered read (READ_LAT=2).
// Expected results come from a counting reference model over the bench's own
// copy of the expected table and register contents.
module tb_regfile_scan_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_valid;

  logic        test0, we0, busy0, done0, pass0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic [5:0]  chk0, cor0;
  logic        test2, we2, busy2, done2, pass2;
  logic [4:0]  addr2;
  logic [31:0] data2;
  logic [5:0]  chk2, cor2;
`ifdef REGCHK_FAIL_CAPTURE_EN
  logic        fs0, fs2;
  logic [4:0]  fr0, fr2;
  logic [31:0] fa0, fa2;
`endif

  // Bench-side register file contents and expected-table mirror.
  logic [31:0] regs_model [32];
  bit          m_v [32];
  logic [31:0] m_d [32];
  logic [31:0] rd_p1, rd_p2;

  int          n_cmp;
  int          n_fail;
  int          m_checked, m_correct, m_fr;
  bit          m_pass, m_fs;
  logic [31:0] m_fa;

  typedef struct {
    logic [31:0] vmask;
    logic [31:0] wmask;
    logic [31:0] base;
    logic [31:0] stride;
    int          e_checked;
    int          e_correct;
    bit          e_pass;
    string       name;
  } vec_t;

  vec_t vecs [6];

  regfile_scan_checker #(.NUM_REGS(32), .DATA_WIDTH(32), .READ_LAT(0)) u0 (
    .clock(clock), .reset(reset), .start(start), .exp_we(exp_we),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_valid(exp_valid),
    .test(test0), .ctrl_writeEnable(we0), .ctrl_readRegA(addr0),
    .data_readRegA(data0), .busy(busy0), .done(done0),
    .num_checked(chk0), .num_correct(cor0), .all_pass(pass0)
`ifdef REGCHK_FAIL_CAPTURE_EN
    , .fail_seen(fs0), .fail_reg(fr0), .fail_actual(fa0)
`endif
  );

  regfile_scan_checker #(.NUM_REGS(32), .DATA_WIDTH(32), .READ_LAT(2)) u2 (
    .clock(clock), .reset(reset), .start(start), .exp_we(exp_we),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_valid(exp_valid),
    .test(test2), .ctrl_writeEnable(we2), .ctrl_readRegA(addr2),
    .data_readRegA(data2), .busy(busy2), .done(done2),
    .num_checked(chk2), .num_correct(cor2), .all_pass(pass2)
`ifdef REGCHK_FAIL_CAPTURE_EN
    , .fail_seen(fs2), .fail_reg(fr2), .fail_actual(fa2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file models: combinational read and two-cycle registered read.
  assign data0 = regs_model[addr0];
  always @(posedge clock) begin
    rd_p1 <= regs_model[addr2];
    rd_p2 <= rd_p1;
  end
  assign data2 = rd_p2;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference: count valid entries and matching entries; first failure in scan order.
  task automatic predict();
    m_checked = 0; m_correct = 0; m_fs = 0; m_fr = 0; m_fa = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (m_v[i]) begin
        m_checked++;
        if (regs_model[i] == m_d[i]) m_correct++;
        else if (!m_fs) begin
          m_fs = 1; m_fr = i; m_fa = regs_model[i];
        end
      end
    end
    m_pass = (m_checked == m_correct);
  endtask

  task automatic write_entry(input int idx, input logic [31:0] d, input bit v);
    @(negedge clock);
    exp_we = 1'b1; exp_addr = 5'(idx); exp_data = d; exp_valid = v;
    m_v[idx] = v; m_d[idx] = d;
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) write_entry(i, 32'h0, 1'b0);
  endtask

  task automatic load_vec(input vec_t v);
    logic [31:0] expv;
    for (int i = 0; i < 32; i++) begin
      expv = v.base + v.stride * 32'(i);
      if (!v.vmask[i])     regs_model[i] = $urandom;
      else if (v.wmask[i]) regs_model[i] = ~expv;
      else                 regs_model[i] = expv;
      write_entry(i, expv, v.vmask[i]);
    end
  endtask

  // One scan on both checkers; optional same-cycle table write and mid-scan noise.
  task automatic run_scan(input string nm, input bit co_wr, input int co_idx,
                          input logic [31:0] co_d, input bit mid_inj);
    int lat0, lat2;
    bit addr_ok;
    @(negedge clock);
    start = 1'b1;
    if (co_wr) begin
      exp_we = 1'b1; exp_addr = 5'(co_idx); exp_data = co_d; exp_valid = 1'b1;
      m_v[co_idx] = 1'b1; m_d[co_idx] = co_d;
    end
    lat0 = 0; lat2 = 0; addr_ok = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clock);
      start = 1'b0; exp_we = 1'b0;
      if (n <= 32 && (addr0 !== 5'(n - 1) || test0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0))
        addr_ok = 1'b0;
      if (mid_inj && n == 12) begin
        start = 1'b1; exp_we = 1'b1; exp_addr = 5'd5; exp_data = 32'd9; exp_valid = 1'b1;
      end
      if (done0 && lat0 == 0) lat0 = n;
      if (done2 && lat2 == 0) lat2 = n;
      if (lat0 != 0 && lat2 != 0) break;
    end
    predict();
    $display("scan %s: lat0=%0d lat2=%0d checked=%0d/%0d correct=%0d/%0d all_pass=%0d/%0d",
             nm, lat0, lat2, chk0, chk2, cor0, cor2, pass0, pass2);
    check({nm, "_lat0"}, 64'(lat0), 64'd33);
    check({nm, "_lat2"}, 64'(lat2), 64'd35);
    check({nm, "_addr_seq"}, 64'(addr_ok), 64'd1);
    check({nm, "_we"}, {62'd0, we0, we2}, 64'd0);
    check({nm, "_checked0"}, 64'(chk0), 64'(m_checked));
    check({nm, "_correct0"}, 64'(cor0), 64'(m_correct));
    check({nm, "_pass0"}, 64'(pass0), 64'(m_pass));
    check({nm, "_checked2"}, 64'(chk2), 64'(m_checked));
    check({nm, "_correct2"}, 64'(cor2), 64'(m_correct));
    check({nm, "_pass2"}, 64'(pass2), 64'(m_pass));
`ifdef REGCHK_FAIL_CAPTURE_EN
    check({nm, "_fail_seen0"}, 64'(fs0), 64'(m_fs));
    check({nm, "_fail_reg0"}, 64'(fr0), 64'(m_fr));
    check({nm, "_fail_act0"}, 64'(fa0), 64'(m_fa));
    check({nm, "_fail_seen2"}, 64'(fs2), 64'(m_fs));
    check({nm, "_fail_reg2"}, 64'(fr2), 64'(m_fr));
    check({nm, "_fail_act2"}, 64'(fa2), 64'(m_fa));
`endif
  endtask

  initial begin
    bit found;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_data = '0; exp_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs_model[i] = 32'h0; m_v[i] = 1'b0; m_d[i] = 32'h0;
    end

    vecs[0] = '{32'h0000_0002, 32'h0000_0000, 32'd65534,     32'd1,         1,  1,  1'b1, "one_r1"};
    vecs[1] = '{32'h0000_000A, 32'h0000_0002, 32'h0000_0000, 32'd7,         2,  1,  1'b0, "r1_bad_r3_ok"};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd0,         0,  0,  1'b1, "empty"};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0,         32, 31, 1'b0, "all_ff_r0_bad"};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h0101_0101, 32, 32, 1'b1, "all_good"};
    vecs[5] = '{32'h8000_0001, 32'h8000_0000, 32'd3,         32'd5,         2,  1,  1'b0, "r31_bad"};

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_test", {62'd0, test0, test2}, 64'd0);
    check("rst_busy", {62'd0, busy0, busy2}, 64'd0);
    check("rst_done", {62'd0, done0, done2}, 64'd0);
    check("rst_all_pass", {62'd0, pass0, pass2}, 64'd0);
    check("rst_addr", {54'd0, addr0, addr2}, 64'd0);
    check("rst_counts", {40'd0, chk0, cor0, chk2, cor2}, 64'd0);
    check("rst_we", {62'd0, we0, we2}, 64'd0);
    reset = 1'b0;

    // Table-driven scenarios, each also held against hand-computed constants.
    for (int k = 0; k < 6; k++) begin
      load_vec(vecs[k]);
      run_scan(vecs[k].name, 1'b0, 0, 32'h0, 1'b0);
      check({vecs[k].name, "_const_checked"}, 64'(chk0), 64'(vecs[k].e_checked));
      check({vecs[k].name, "_const_correct"}, 64'(cor0), 64'(vecs[k].e_correct));
      check({vecs[k].name, "_const_pass"}, 64'(pass0), 64'(vecs[k].e_pass));
    end

    // r1 expects 65535 but holds 65534; r3 expects and holds 7.
    clear_table();
    regs_model[1] = 32'd65534; regs_model[3] = 32'd7;
    write_entry(1, 32'd65535, 1'b1);
    write_entry(3, 32'd7, 1'b1);
    run_scan("r1_65534", 1'b0, 0, 32'h0, 1'b0);
    check("r1_65534_const", {52'd0, chk0, cor0}, {52'd0, 6'd2, 6'd1});

    // Same-address rewrite: the last write wins.
    clear_table();
    regs_model[4] = 32'h44;
    write_entry(4, 32'h1, 1'b1);
    write_entry(4, 32'h44, 1'b1);
    run_scan("last_write_wins", 1'b0, 0, 32'h0, 1'b0);

    // Write in the same cycle as start: the scan sees the new entry.
    clear_table();
    regs_model[2] = 32'hABCD;
    run_scan("start_with_write", 1'b1, 2, 32'hABCD, 1'b0);
    check("start_with_write_const", {52'd0, chk0, cor0}, {52'd0, 6'd1, 6'd1});

    // Start and table write mid-scan are ignored; a rescan starts from zero counts.
    load_vec(vecs[0]);
    regs_model[5] = 32'h5555_0000;
    run_scan("midscan_noise", 1'b0, 0, 32'h0, 1'b1);
    run_scan("rescan", 1'b0, 0, 32'h0, 1'b0);
    check("rescan_const", {52'd0, chk0, cor0}, {52'd0, 6'd1, 6'd1});

    // Reset in the middle of a scan.
    load_vec(vecs[4]);
    @(negedge clock);
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (addr0 == 5'd10 && busy0) found = 1'b1;
    end
    check("midrst_reach_addr10", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_test_busy", {60'd0, test0, busy0, test2, busy2}, 64'd0);
    check("midrst_done", {62'd0, done0, done2}, 64'd0);
    check("midrst_counts", {40'd0, chk0, cor0, chk2, cor2}, 64'd0);
    check("midrst_addr", {54'd0, addr0, addr2}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
    run_scan("after_reset_empty", 1'b0, 0, 32'h0, 1'b0);
    check("after_reset_const", {51'd0, chk0, cor0, pass0}, {51'd0, 6'd0, 6'd0, 1'b1});

    // Randomized tables checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        logic [31:0] d;
        bit v;
        d = $urandom;
        v = ($urandom_range(0, 2) != 0);
        regs_model[i] = ($urandom_range(0, 3) == 0) ? (d ^ (32'h1 << $urandom_range(0, 31))) : d;
        write_entry(i, d, v);
      end
      run_scan($sformatf("random_%0d", r), 1'b0, 0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
